// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, key-expander state encoding, Rcon and word/byte helpers.
// Used by the key expander and by the SubBytes/AddRoundKey datapath.
package aes_pkg;

   localparam int unsigned AES_NUM_ROUNDS = 10;
   localparam int unsigned AES_NUM_WORDS  = 44;
   localparam int unsigned AES_WORD_W     = 32;
   localparam int unsigned AES_BYTE_W     = 8;
   localparam int unsigned AES_IDX_W      = 6;
   localparam int unsigned AES_ROUND_W    = 4;
   localparam int unsigned AES_COL_W      = 2;

   typedef logic [AES_WORD_W-1:0] aes_word_t;
   typedef logic [AES_BYTE_W-1:0] aes_byte_t;

   typedef enum logic [1:0] {
      KX_IDLE   = 2'd0,
      KX_LOAD   = 2'd1,
      KX_EXPAND = 2'd2,
      KX_DONE   = 2'd3
   } kx_state_e;

   // Round constant for Rcon index 1..10; other indices yield zero.
   function automatic aes_byte_t aes_rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Row 0 lives in the most significant byte of a column word.
   function automatic aes_byte_t aes_get_byte(input aes_word_t w, input logic [1:0] row);
      case (row)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   function automatic aes_word_t aes_pack_word(input aes_byte_t b0, input aes_byte_t b1,
                                               input aes_byte_t b2, input aes_byte_t b3);
      return {b0, b1, b2, b3};
   endfunction

   // Left byte rotate {b1,b2,b3,b0}.
   function automatic aes_word_t aes_rot_word(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, shared by SubWord and SubBytes.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] data_i,
   output logic [AES_BYTE_W-1:0] data_o
);

   localparam logic [AES_BYTE_W-1:0] SBOX_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign data_o = SBOX_TABLE[data_i];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: loads four key words, expands w4..w43 one word per cycle,
// and serves round-key columns through a combinational read port.
module aes_key_expander
   import aes_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   key_start,
   input  logic [AES_WORD_W-1:0]  key_word_in,
   input  logic [AES_ROUND_W-1:0] rk_round,
   input  logic [AES_COL_W-1:0]   rk_col,
   output logic [AES_WORD_W-1:0]  rk_word,
   output logic                   key_expand_done,
   output logic                   busy
);

   kx_state_e               state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [AES_IDX_W-1:0]    idx_q, idx_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   aes_word_t               w_q [AES_NUM_WORDS];

   logic                    wr_en;
   logic [AES_IDX_W-1:0]    wr_idx;
   aes_word_t               wr_data;

   aes_word_t               prev_word;
   aes_word_t               back_word;
   aes_word_t               rot_word;
   aes_word_t               sub_word;
   aes_word_t               temp_word;
   aes_byte_t               sub_bytes [4];
   logic [AES_IDX_W-1:0]    rd_idx;

   // Schedule recurrence operands: w[i-1] and w[i-4].
   assign prev_word = w_q[idx_q - 6'd1];
   assign back_word = w_q[idx_q - 6'd4];
   assign rot_word  = aes_rot_word(prev_word);

   for (genvar r = 0; r < 4; r++) begin : g_subword
      aes_sbox u_sbox (
         .data_i (aes_get_byte(rot_word, 2'(r))),
         .data_o (sub_bytes[r])
      );
   end

   assign sub_word  = aes_pack_word(sub_bytes[0], sub_bytes[1], sub_bytes[2], sub_bytes[3]);
   assign temp_word = (idx_q[1:0] == 2'b00)
                    ? (sub_word ^ {aes_rcon(idx_q[5:2]), 24'h000000})
                    : prev_word;

   // Next-state and register-file write control; key_start restarts from any state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      done_d  = done_q;
      busy_d  = busy_q;
      wr_en   = 1'b0;
      wr_idx  = idx_q;
      wr_data = '0;

      if (key_start) begin
         state_d = KX_LOAD;
         cnt_d   = 2'd0;
         idx_d   = '0;
         done_d  = 1'b0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            KX_IDLE: ;
            KX_LOAD: begin
               wr_en   = 1'b1;
               wr_idx  = {4'b0000, cnt_q};
               wr_data = key_word_in;
               if (cnt_q == 2'd3) begin
                  state_d = KX_EXPAND;
                  cnt_d   = 2'd0;
                  idx_d   = 6'd4;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            KX_EXPAND: begin
               wr_en   = 1'b1;
               wr_idx  = idx_q;
               wr_data = back_word ^ temp_word;
               if (idx_q == 6'(AES_NUM_WORDS - 1)) begin
                  state_d = KX_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
            KX_DONE: ;
            default: state_d = KX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= KX_IDLE;
         cnt_q   <= 2'd0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Flop-based round-key file; cleared by reset so no stale key survives.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < AES_NUM_WORDS; k++) begin
            w_q[k] <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < AES_NUM_WORDS; k++) begin
            if (wr_idx == 6'(k)) begin
               w_q[k] <= wr_data;
            end
         end
      end
   end

   // 4*round + col is just the concatenation of the two selects.
   assign rd_idx  = {rk_round, rk_col};
   assign rk_word = (rk_round > 4'(AES_NUM_ROUNDS)) ? '0 : w_q[rd_idx];

   assign key_expand_done = done_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expander;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        key_start = 1'b0;
   logic [31:0] key_word_in = '0;
   logic [3:0]  rk_round = '0;
   logic [1:0]  rk_col = '0;
   logic [31:0] rk_word;
   logic        key_expand_done;
   logic        busy;

   aes_key_expander dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .key_start       (key_start),
      .key_word_in     (key_word_in),
      .rk_round        (rk_round),
      .rk_col          (rk_col),
      .rk_word         (rk_word),
      .key_expand_done (key_expand_done),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_start = 0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct packed {
      logic [3:0]  r;
      logic [1:0]  c;
      logic [31:0] exp;
   } rd_item_t;

   rd_item_t    exp_q [$];
   logic        rd_valid = 1'b0;
   logic [7:0]  sb [256];
   logic [31:0] gold [44];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_KEY = 128'h0;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] a);
      logic [7:0] inv = 8'h00;
      if (a != 8'h00) begin
         for (int y = 1; y < 256; y++) begin
            if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
         end
      end
      return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic build_gold(input logic [127:0] key);
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) gold[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = gold[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         gold[i] = gold[i-4] ^ t;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input int r, input int c, input logic [31:0] exp);
      rd_item_t it;
      @(posedge clock);
      #1;
      rk_round = 4'(r);
      rk_col   = 2'(c);
      rd_valid = 1'b1;
      it.r = 4'(r);
      it.c = 2'(c);
      it.exp = exp;
      exp_q.push_back(it);
   endtask

   task automatic end_reads();
      @(posedge clock);
      #1;
      rd_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic sweep();
      for (int r = 0; r <= 10; r++)
         for (int c = 0; c < 4; c++) issue(r, c, gold[4*r+c]);
      for (int k = 0; k < 3; k++) issue(int'($urandom_range(11, 15)), int'($urandom_range(0, 3)), 32'h0);
      issue(15, 0, 32'h0);
      end_reads();
   endtask

   // Caller is positioned at a negedge.
   task automatic pulse_start();
      key_start = 1'b1;
      @(negedge clock);
      key_start = 1'b0;
      t_start   = cyc;
   endtask

   task automatic load_words(input logic [127:0] key);
      for (int j = 0; j < 4; j++) begin
         key_word_in = key[127-32*j -: 32];
         if (j == 0) chk("busy_in_load", 32'(busy), 32'd1);
         @(negedge clock);
      end
   endtask

   task automatic wait_done(input string nm);
      int waited = 0;
      while (!key_expand_done && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      chk({nm, "_done_seen"}, 32'(key_expand_done), 32'd1);
      chk({nm, "_latency"}, 32'(cyc - t_start), 32'd44);
      chk({nm, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      rd_item_t it;
      forever begin
         @(negedge clock);
         if (rd_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rd_unexpected: got %h expected no read", rk_word);
            end else begin
               it = exp_q.pop_front();
               if (rk_word !== it.exp) begin
                  n_fail++;
                  $display("FAIL rk[%0d][%0d]: got %h expected %h", it.r, it.c, rk_word, it.exp);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [127:0] rkey;
      for (int k = 0; k < 256; k++) sb[k] = sbox_ref(8'(k));

      repeat (3) @(negedge clock);
      chk("reset_done", 32'(key_expand_done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 44; i++) gold[i] = 32'h0;
      sweep();

      // FIPS-197 key
      pulse_start();
      load_words(FIPS_KEY);
      wait_done("fips");
      build_gold(FIPS_KEY);
      sweep();
      issue(1, 0, 32'ha0fafe17); issue(1, 1, 32'h88542cb1);
      issue(1, 2, 32'h23a33939); issue(1, 3, 32'h2a6c7605);
      issue(10, 0, 32'hd014f9a8); issue(10, 1, 32'hc9ee2589);
      issue(10, 2, 32'he13f0cc8); issue(10, 3, 32'hb6630ca6);
      end_reads();

      // Back-to-back: zero key started the cycle after DONE
      pulse_start();
      load_words(FIPS_KEY);
      wait_done("fips2");
      pulse_start();
      chk("b2b_done_cleared", 32'(key_expand_done), 32'd0);
      load_words(ZERO_KEY);
      wait_done("zero");
      build_gold(ZERO_KEY);
      sweep();
      issue(1, 0, 32'h62636363);
      issue(10, 0, 32'hb4ef5bcb); issue(10, 1, 32'h3e92e211);
      issue(10, 2, 32'h23e951cf); issue(10, 3, 32'h6f8f188e);
      end_reads();

      // Restart at EXPAND i=20 with done previously high
      rkey = {$urandom, $urandom, $urandom, $urandom};
      pulse_start();
      chk("restart_done_cleared", 32'(key_expand_done), 32'd0);
      load_words(rkey);
      repeat (16) @(negedge clock);
      pulse_start();
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_done_low", 32'(key_expand_done), 32'd0);
      load_words(FIPS_KEY);
      wait_done("restart");
      build_gold(FIPS_KEY);
      sweep();

      // Random keys
      for (int n = 0; n < 3; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         pulse_start();
         load_words(rkey);
         wait_done("rand");
         build_gold(rkey);
         sweep();
      end

      // Asynchronous reset during EXPAND
      rkey = {$urandom, $urandom, $urandom, $urandom};
      pulse_start();
      load_words(rkey);
      repeat (10) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(key_expand_done), 32'd0);
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 4; c++) begin
            rk_round = 4'(r);
            rk_col   = 2'(c);
            #1;
            chk($sformatf("async_rst_rk[%0d][%0d]", r, c), rk_word, 32'h0);
         end
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (50) @(negedge clock);
      chk("post_rst_done", 32'(key_expand_done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
